// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared defaults and width helper for the round-robin stream mux
package rr_mux_pkg;
  localparam int N_DEFAULT     = 4;
  localparam int WIDTH_DEFAULT = 8;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: rotate, fixed-priority encode, un-rotate
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int CH_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any
);
  logic [2*N-1:0]  req2;
  logic [N-1:0]    rot;
  logic [CH_W-1:0] off;
  logic [CH_W:0]   sum;

  always_comb begin
    // Doubling the request vector turns the rotation into a plain shift.
    req2 = {req, req} >> ptr;
    rot  = req2[N-1:0];
    off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
    // Explicit wrap keeps the index below N when N is not a power of two.
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (CH_W + 1)'(N)) sum = sum - (CH_W + 1)'(N);
    grant = sum[CH_W-1:0];
    any   = |req;
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel registered round-robin stream mux (optional RR_STREAM_MUX_FORCE_SEL_EN)
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CH_W  = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]      out_ch,
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
  input  logic                 force_en,
  input  logic [CH_W-1:0]      force_sel,
`endif
  input  logic                 out_ready
);
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  rr_grant;
  logic             rr_any;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  next_ptr;
  logic             any_v;
  logic             upd_ptr;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.N(N), .CH_W(CH_W)) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .any   (rr_any)
  );

  always_comb begin
    grant   = rr_grant;
    any_v   = rr_any;
    upd_ptr = 1'b1;
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
    // Forced select behaves like a plain selector; out-of-range selects never match a channel.
    if (force_en) begin
      grant   = force_sel;
      upd_ptr = 1'b0;
      any_v   = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (force_sel == CH_W'(k)) any_v = in_valid[k];
      end
    end
`endif
  end

  assign load     = !out_valid || out_ready;
  assign next_ptr = (grant == CH_W'(N - 1)) ? '0 : grant + CH_W'(1);

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = load && any_v && !rst && (grant == CH_W'(k));
      if (grant == CH_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_v) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant;
        if (upd_ptr) ptr <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the team's 4:1 gate-level multiplexer: an N-channel, WIDTH-bit registered stream multiplexer.
- Channel select is internal: a round-robin pointer replaces the external select lines.
- Valid/ready handshakes are used on every input channel and on the output.
- It merges N producer streams into one consumer stream, with one output register stage, full throughput and fair arbitration.

Parameters:
- N, 4: number of input channels, 1..16.
- WIDTH, 8: data width per channel, at least 1.
- CH_W, $clog2(N) with a minimum of 1: width of the channel index. Derived; must not be overridden.

Ports:
- clk, input, 1: clock; all state is updated on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, N: per-channel valid.
- in_data, input, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready, output, N: per-channel accept; one-hot or zero.
- out_valid, output, 1: output register holds data.
- out_data, output, WIDTH: registered data.
- out_ch, output, CH_W: index of the source channel of out_data.
- out_ready, input, 1: consumer accept.

Behaviour:
- Reset (asynchronous, active-high, on clk/rst):
  - out_valid=0, out_data=0, out_ch=0, ptr=0.
  - in_ready is all-zero while rst is asserted.
  - Data held at reset is discarded and never presented.
- Output register load:
  - load = !out_valid || out_ready.
  - When load is low, the output register holds and all in_ready bits are 0.
- Grant:
  - grant is the first channel k with in_valid[k]=1, searching cyclically ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - any_v = |in_valid.
- in_ready is combinational: in_ready[grant] = load && any_v; all other bits are 0.
  - A transfer on channel k occurs when in_valid[k] && in_ready[k].
- On a clock edge with load=1 and any_v=1:
  - out_data <= data of grant; out_ch <= grant; out_valid <= 1.
  - ptr <= grant+1, wrapping N-1 to 0.
- On a clock edge with load=1 and any_v=0:
  - out_valid <= 0; out_data and out_ch hold; ptr holds.
- Latency and throughput:
  - Input-to-output latency is exactly 1 cycle.
  - One transfer per cycle is sustained while out_ready=1.
- Simultaneous pop and push: out_ready=1 with out_valid=1 in the same cycle as a new grant is a back-to-back transfer. There is no bubble.
- Stall:
  - out_valid, out_data and out_ch remain stable until accepted.
  - Input valid may stay asserted indefinitely without being lost.
- Fairness: under continuous requests from all N channels, each channel is granted exactly once per N consecutive grants.
- Width and wrap rules:
  - When N is not a power of two, ptr must never hold a value of N or above; the wrap is explicit, not modulo 2^CH_W.
  - For N=1, grant is always 0 and CH_W is 1.
- Input protocol: producers must not drop in_valid or change in_data before the transfer occurs. This is a bench assertion, not a checked condition in RTL.

Optional Feature:
- Macro: RR_STREAM_MUX_FORCE_SEL_EN.
- When defined, two extra ports are added:
  - force_en, input, 1.
  - force_sel, input, CH_W.
- While force_en=1, grant = force_sel, in the manner of a plain selector.
  - Transfer occurs only if in_valid[force_sel]=1; otherwise no transfer and in_ready is all-zero.
  - ptr is not updated.
  - force_sel ≥ N acts as no request.
- When not defined, the ports are absent and behaviour is pure round-robin.

Decomposition:
- Shared package rr_mux_pkg contains:
  - function clog2_min1(n), used to derive CH_W.
  - localparam defaults for N and WIDTH.
- Sub-module rr_pick, purely combinational:
  - Inputs: req[N], ptr[CH_W].
  - Outputs: grant[CH_W], any.
  - Implementation: rotate, fixed-priority encode, un-rotate.
  - Verified standalone.
- The top level holds ptr, the output register and the handshake logic.

Test Plan (N=4, WIDTH=8):
- Reset check: assert rst mid-stream with out_valid=1 and out_data=0x5A → out_valid=0, out_data=0, in_ready=0000 immediately, without waiting for a clk edge; ptr=0 after release.
- Round-robin: all four valid, with data 0x10/0x11/0x12/0x13, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid continuously 1; out_data tracks out_ch.
- Sparse requests: only channels 1 and 3 valid, ptr=2 → grants 3,1,3,1; ptr after the first grant is 0.
- Back-pressure: out_ready=0 for 5 cycles with ch2 valid and data 0xA7 → out_data=0xA7 held stable, in_ready=0000 after the first load; first cycle with out_ready=1 gives a transfer plus a new load in the same cycle.
- Idle gap: all valids drop for 3 cycles → out_valid falls 1 cycle after the last accept; ptr holds; on resume, the grant continues from ptr.
- Macro build (RR_STREAM_MUX_FORCE_SEL_EN): force_en=1, force_sel=2, all four valid → ch2 granted every cycle, ptr unchanged. force_sel=2 with in_valid[2]=0 → no transfer.
